// File: rtl/asym_width_dual_port_ram.sv
// Simple dual-port RAM with power-of-two write/read width ratio, byte strobes and a 1/2-cycle read pipeline.
// Define ASYM_RAM_WRITE_FORWARD_EN for write-first same-cycle overlap; default is read-first.
module asym_width_dual_port_ram #(
    parameter int WRITE_DATA_WIDTH = 32,
    parameter int READ_DATA_WIDTH  = 64,
    parameter int MEM_BYTES        = 1024,
    parameter int READ_LATENCY     = 1,
    parameter int WRITE_ADDR_WIDTH = $clog2(MEM_BYTES*8/WRITE_DATA_WIDTH),
    parameter int READ_ADDR_WIDTH  = $clog2(MEM_BYTES*8/READ_DATA_WIDTH)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [WRITE_ADDR_WIDTH-1:0]   write_addr,
    input  logic [WRITE_DATA_WIDTH-1:0]   write_data,
    input  logic [WRITE_DATA_WIDTH/8-1:0] write_strb,
    input  logic [READ_ADDR_WIDTH-1:0]    read_addr,
    input  logic                          read_enable,
    output logic [READ_DATA_WIDTH-1:0]    read_data,
    output logic                          read_valid
);

    localparam int WB      = WRITE_DATA_WIDTH / 8;
    localparam int RB      = READ_DATA_WIDTH / 8;
    localparam int NB      = (WB < RB) ? WB : RB;
    localparam int ENTRIES = MEM_BYTES / NB;
    localparam int EW      = $clog2(ENTRIES);
    localparam int WE      = WB / NB;
    localparam int RE      = RB / NB;
    localparam int WE_LG   = $clog2(WE);
    localparam int RE_LG   = $clog2(RE);

    typedef logic [NB-1:0][7:0] entry_t;

    entry_t mem_q [ENTRIES];

    logic [WE-1:0][NB-1:0][7:0] wbytes;
    logic [WE-1:0][NB-1:0]      wstrb;
    logic [WE-1:0][EW-1:0]      widx;
    logic [RE-1:0][EW-1:0]      ridx;
    logic [RE-1:0][NB-1:0][7:0] rbytes;

    assign wbytes = write_data;
    assign wstrb  = write_strb;

    // A word spans WE (or RE) consecutive entries; the word address forms the upper index bits.
    always_comb begin
        widx = '0;
        for (int k = 0; k < WE; k++) begin
            widx[k] = (EW'(write_addr) << WE_LG) | EW'(k);
        end
        ridx = '0;
        for (int k = 0; k < RE; k++) begin
            ridx[k] = (EW'(read_addr) << RE_LG) | EW'(k);
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < WE; k++) begin
            for (int b = 0; b < NB; b++) begin
                if (wstrb[k][b]) begin
                    mem_q[widx[k]][b] <= wbytes[k][b];
                end
            end
        end
    end

    always_comb begin
        rbytes = '0;
        for (int k = 0; k < RE; k++) begin
            rbytes[k] = mem_q[ridx[k]];
        end
`ifdef ASYM_RAM_WRITE_FORWARD_EN
        // Strobed bytes of the write being committed this edge override the stored copy.
        for (int k = 0; k < RE; k++) begin
            for (int m = 0; m < WE; m++) begin
                for (int b = 0; b < NB; b++) begin
                    if (ridx[k] == widx[m] && wstrb[m][b]) begin
                        rbytes[k][b] = wbytes[m][b];
                    end
                end
            end
        end
`endif
    end

    logic                       stage_vld;
    logic [READ_DATA_WIDTH-1:0] stage_data;

    if (READ_LATENCY == 2) begin : g_lat2
        logic                       s1_vld_q, s1_vld_d;
        logic [READ_DATA_WIDTH-1:0] s1_data_q, s1_data_d;

        always_comb begin
            s1_vld_d  = read_enable;
            s1_data_d = read_enable ? READ_DATA_WIDTH'(rbytes) : s1_data_q;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1_vld_q  <= 1'b0;
                s1_data_q <= '0;
            end else begin
                s1_vld_q  <= s1_vld_d;
                s1_data_q <= s1_data_d;
            end
        end

        assign stage_vld  = s1_vld_q;
        assign stage_data = s1_data_q;
    end else begin : g_lat1
        assign stage_vld  = read_enable;
        assign stage_data = READ_DATA_WIDTH'(rbytes);
    end

    logic                       read_valid_q, read_valid_d;
    logic [READ_DATA_WIDTH-1:0] read_data_q, read_data_d;

    always_comb begin
        read_valid_d = stage_vld;
        read_data_d  = stage_vld ? stage_data : read_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_valid_q <= 1'b0;
            read_data_q  <= '0;
        end else begin
            read_valid_q <= read_valid_d;
            read_data_q  <= read_data_d;
        end
    end

    assign read_valid = read_valid_q;
    assign read_data  = read_data_q;

endmodule

// File: doc/asym_width_dual_port_ram.md
# asym_width_dual_port_ram

Simple dual-port RAM with independent write and read data widths related by any power-of-two ratio, in either direction. Byte-granular write strobes and a little-endian byte mapping are shared by both ports. A registered read pipeline has 1 or 2 cycles of latency and a valid flag. Used as the reorder/holding store inside the AXI width converters (narrow→wide and wide→narrow write/read paths).

## Interface
- `WRITE_DATA_WIDTH`, 32, write port width in bits; multiple of 8, power of two.
- `READ_DATA_WIDTH`, 64, read port width in bits; multiple of 8, power of two.
- `MEM_BYTES`, 1024, total capacity in bytes; power of two, ≥ max(W,R)/8.
- `READ_LATENCY`, 1, read_enable→read_valid latency in cycles; legal values 1 or 2.
- `WRITE_ADDR_WIDTH`, $clog2(MEM_BYTES*8/WRITE_DATA_WIDTH), write word address width.
- `READ_ADDR_WIDTH`, $clog2(MEM_BYTES*8/READ_DATA_WIDTH), read word address width.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `write_addr`  in  WRITE_ADDR_WIDTH  write word address.
- `write_data`  in  WRITE_DATA_WIDTH  write data.
- `write_strb`  in  WRITE_DATA_WIDTH/8  byte strobes; bit i covers write_data[8i+:8].
- `read_addr`  in  READ_ADDR_WIDTH  read word address.
- `read_enable`  in  1  read request, sampled each cycle.
- `read_data`  out  READ_DATA_WIDTH  read result; holds its value between reads.
- `read_valid`  out  1  read_data carries the result of the request issued READ_LATENCY cycles earlier.

## Operation
- Storage is organised as byte lanes of width NARROW = min(W,R)/8 bytes per entry. There are MEM_BYTES/NARROW entries. Storage is not reset.
- Byte mapping: write byte i of write word A lands at byte address A*(W/8)+i. Read byte j of read word B comes from byte address B*(R/8)+j. Both mappings are little-endian.
- Write (W≥R): one write word spans W/R entries. Each byte is written only if its strobe bit is 1. write_strb=0 writes nothing.
- Write (W<R): exactly one entry is written, selected by write_addr.
- Read (R≥W): R/W consecutive entries are concatenated, lowest address in the LSBs.
- Read (R<W): one entry is returned.
- Read-during-write to overlapping bytes in the same cycle: see Configuration.
- No addresses are out of range; addresses are used modulo capacity by construction.
- Reset (rst_n low, asynchronous): read_data=0, read_valid=0, and the pipeline stage-1 valid bit = 0. Requests in flight are dropped. Storage contents are unchanged.

## Timing
- READ_LATENCY=1:
  - read_enable at edge N → read_data and read_valid=1 after edge N.
  - read_valid is high for exactly the cycle following each accepted request.
- READ_LATENCY=2:
  - Stage 1 registers the RAM output and a valid bit; stage 2 registers read_data and read_valid.
  - The result appears after edge N+1.
- Both latencies are fully pipelined: back-to-back read_enable produces back-to-back read_valid in order.
- Writes take effect at the rising edge where strobes are sampled. A read issued on a later cycle sees the new data.
- When read_valid is 0, read_data keeps its last value (not forced to zero, except at reset).
- Reset asserted mid-pipeline: read_valid goes low immediately, and no stale valid appears after rst_n deasserts.
- rst_n deassertion is synchronised externally. The first request is accepted at the first edge with rst_n high.

## Configuration
- Macro: `ASYM_RAM_WRITE_FORWARD_EN`.
- Defined (write-first): on a same-cycle read/write overlap, each overlapping byte with its strobe set returns the new write_data byte. All other bytes return stored data.
- Undefined (read-first): a same-cycle read returns the pre-write contents for all bytes.
- Both modes: a read one cycle or more after a write sees the new data.

## Test plan
- W=32, R=64, latency 1:
  - write addr 0 data 0x11223344 strb 0xF, then addr 1 data 0x55667788 strb 0xF.
  - Read addr 0 → read_data=0x5566778811223344 and read_valid high for 1 cycle.
- W=64, R=32, latency 2:
  - write addr 3 data 0xAABBCCDD_01020304 strb 0xFF.
  - Read addr 6 → 0x01020304 and read addr 7 → 0xAABBCCDD, each 2 cycles after its read_enable.
- Strobe masking:
  - Preload addr 0 = 0xFFFFFFFF, then write 0x12345678 strb 0x5.
  - Read → 0xFF34FF78.
- Same-cycle overlap: memory 0x00000000, write 0xDEADBEEF strb 0xF with a read of the same address.
  - With the macro → 0xDEADBEEF.
  - Without the macro → 0x00000000.
  - The next-cycle read returns 0xDEADBEEF in both modes.
- Streaming, latency 2: read_enable high for 8 cycles on addrs 0..7.
  - Expect 8 consecutive read_valid pulses starting 2 cycles later, data in address order.
- Reset mid-pipeline: issue a read, then assert rst_n low before read_valid.
  - read_valid=0 and read_data=0 immediately.
  - After release, no spurious valid appears.
  - Memory contents still read back unchanged.
